// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage datapath.
// Generates the control-bubble select (op), PC / IF-ID enables, IF-ID flush,
// a global hold for multi-cycle data-memory accesses, and a saturating
// count of cycles lost to stalls, flushes and holds.
module hazard_ctrl #(
    parameter int MEM_LAT     = 1,   // data-memory latency, 1..15 (1 = no wait)
    parameter int FLUSH_SLOTS = 1,   // wrong-path slots squashed per taken branch, 1..7
    parameter int CNT_W       = 16   // stall counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_access,
    input  logic             branch_taken,
    output logic             op,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    // Reload values: the trigger cycle itself is already the first held /
    // flushed cycle, hence the "-2".
    localparam logic [3:0] MEM_LOAD = 4'((MEM_LAT >= 2) ? MEM_LAT - 2 : 0);
    localparam logic [2:0] FL_LOAD  = 3'((FLUSH_SLOTS >= 2) ? FLUSH_SLOTS - 2 : 0);
    localparam logic       WAIT_EN  = (MEM_LAT > 1);
    localparam logic       FL_EN    = (FLUSH_SLOTS > 1);

    logic [0:0] state, stateNxt;
    logic [2:0] flCnt, flCntNxt;
    logic [3:0] memCnt;
    logic       waited;
    logic       loadUse, memTrig, hold, stallEv;

    assign loadUse = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // A new wait starts only on an idle counter and not on the release cycle
    // of the previous access (the same access is still presented then).
    assign memTrig = WAIT_EN && (memCnt == 4'd0) && mem_access && !waited;
    assign hold    = (memCnt != 4'd0) || memTrig;

    // Output decode and next-state: hold > flush > load-use.
    always_comb begin
        op         = 1'b1;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        pipe_hold  = 1'b0;
        stateNxt   = state;
        flCntNxt   = flCnt;
        if (!rst_n) begin
            // reset values held on the outputs while reset is asserted
        end else if (hold) begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (state == FLUSH) begin
            ifid_flush = 1'b1;
            op         = 1'b0;
            if (flCnt == 3'd0) stateNxt = RUN;
            else               flCntNxt = flCnt - 3'd1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            op         = 1'b0;
            if (FL_EN) begin
                stateNxt = FLUSH;
                flCntNxt = FL_LOAD;
            end
        end else if (loadUse) begin
            op         = 1'b0;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
    end

    assign stallEv = pipe_hold || !op || ifid_flush;

    // Main FSM and flush-slot counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            flCnt <= 3'd0;
        end else begin
            state <= stateNxt;
            flCnt <= flCntNxt;
        end
    end

    // Memory-wait counter; waited marks the release cycle of an access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memCnt <= 4'd0;
            waited <= 1'b0;
        end else if (hold) begin
            memCnt <= memTrig ? MEM_LOAD : memCnt - 4'd1;
            waited <= memTrig ? (MEM_LOAD == 4'd0) : (memCnt == 4'd1);
        end else begin
            memCnt <= 4'd0;
            waited <= 1'b0;
        end
    end

    // Saturating count of lost cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stallEv && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Two instances share all inputs:
// A (MEM_LAT=4, FLUSH_SLOTS=3, CNT_W=4) and B (MEM_LAT=2, FLUSH_SLOTS=1, CNT_W=16).
// A cycle-level reference model tracks remaining hold / flush cycles.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic [4:0] idRs = '0, idRt = '0, exRt = '0;
    logic idUsesRt = 1'b0, exMemRead = 1'b0, memAccess = 1'b0, branchTaken = 1'b0;

    logic opA, pcA, ifA, flA, hdA, opB, pcB, ifB, flB, hdB;
    logic [3:0]  stA;
    logic [15:0] stB;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_LAT(4), .FLUSH_SLOTS(3), .CNT_W(4)) dutA (
        .clk(clk), .rst_n(rstN), .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt),
        .ex_mem_read(exMemRead), .ex_rt(exRt), .mem_access(memAccess),
        .branch_taken(branchTaken), .op(opA), .pc_write(pcA), .ifid_write(ifA),
        .ifid_flush(flA), .pipe_hold(hdA), .stall_cnt(stA));

    hazard_ctrl #(.MEM_LAT(2), .FLUSH_SLOTS(1), .CNT_W(16)) dutB (
        .clk(clk), .rst_n(rstN), .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt),
        .ex_mem_read(exMemRead), .ex_rt(exRt), .mem_access(memAccess),
        .branch_taken(branchTaken), .op(opB), .pc_write(pcB), .ifid_write(ifB),
        .ifid_flush(flB), .pipe_hold(hdB), .stall_cnt(stB));

    // ---------------- reference model ----------------
    // Output vector: {op, pc_write, ifid_write, ifid_flush, pipe_hold, stall_cnt[15:0]}
    int lat[2]   = '{4, 2};
    int slots[2] = '{3, 1};
    int cmax[2]  = '{15, 65535};
    int holdLeft[2]  = '{0, 0};   // held cycles still to come for the current access
    int released[2]  = '{0, 0};   // 1 on the cycle right after an access's last held cycle
    int flushLeft[2] = '{0, 0};   // wrong-path cycles still to squash
    int cnt[2]       = '{0, 0};
    int nHold[2], nRel[2], nFlush[2], nCnt[2];
    logic [20:0] expV[2];
    logic [20:0] gotA, gotB;

    task automatic modelEval();
        for (int i = 0; i < 2; i++) begin
            bit o, p, w, f, h, lu;
            o = 1; p = 1; w = 1; f = 0; h = 0;
            lu = exMemRead && exRt != 0 && (exRt == idRs || (idUsesRt && exRt == idRt));
            if (!rstN) begin
                nHold[i] = 0; nRel[i] = 0; nFlush[i] = 0; nCnt[i] = 0;
                expV[i] = {5'b11100, 16'd0};
            end else begin
                h = (holdLeft[i] > 0) || (memAccess && lat[i] > 1 && released[i] == 0);
                nFlush[i] = flushLeft[i];
                if (h) begin
                    nHold[i] = ((holdLeft[i] > 0) ? holdLeft[i] : lat[i] - 1) - 1;
                    nRel[i]  = (nHold[i] == 0);
                    p = 0; w = 0;
                end else begin
                    nHold[i] = 0; nRel[i] = 0;
                    if (flushLeft[i] > 0) begin
                        f = 1; o = 0; nFlush[i] = flushLeft[i] - 1;
                    end else if (branchTaken) begin
                        f = 1; o = 0; nFlush[i] = slots[i] - 1;
                    end else if (lu) begin
                        o = 0; p = 0; w = 0;
                    end
                end
                nCnt[i] = (h || !o || f) ? ((cnt[i] < cmax[i]) ? cnt[i] + 1 : cnt[i]) : cnt[i];
                expV[i] = {o, p, w, f, h, 16'(cnt[i])};
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        modelEval();
        gotA = {opA, pcA, ifA, flA, hdA, 12'd0, stA};
        gotB = {opB, pcB, ifB, flB, hdB, stB};
    endtask

    task automatic advance();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            holdLeft[i] = nHold[i]; released[i] = nRel[i];
            flushLeft[i] = nFlush[i]; cnt[i] = nCnt[i];
        end
        #1;
    endtask

    task automatic clearIn();
        idRs = 0; idRt = 0; exRt = 0; idUsesRt = 0;
        exMemRead = 0; memAccess = 0; branchTaken = 0;
    endtask

    task automatic pulseReset();
        rstN = 0; sample(); advance(); rstN = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clearIn(); rstN = 0;
        sample();
        compared++;
        if (gotA !== 21'h1C0000) begin mismatched++; $display("FAIL reset_A got=%h exp=%h", gotA, 21'h1C0000); end
        compared++;
        if (gotB !== 21'h1C0000) begin mismatched++; $display("FAIL reset_B got=%h exp=%h", gotB, 21'h1C0000); end
        advance(); rstN = 1;
        // Enter a memory wait on A, then reset in the middle of it.
        memAccess = 1;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) rstN = 0;
            if (c == 3) rstN = 1;
            if (c == 3) memAccess = 0;
            sample();
            compared++;
            if (gotA !== expV[0]) begin mismatched++; $display("FAIL reset_mid_wait_A c=%0d got=%h exp=%h", c, gotA, expV[0]); end
            compared++;
            if (gotB !== expV[1]) begin mismatched++; $display("FAIL reset_mid_wait_B c=%0d got=%h exp=%h", c, gotB, expV[1]); end
            if (c == 2) begin
                compared++;
                if ({hdA, stA} !== 5'b0_0000) begin mismatched++; $display("FAIL reset_hold_A got=%b exp=00000", {hdA, stA}); end
            end
            advance();
        end
    endtask

    task automatic test_load_use();
        clearIn(); pulseReset();
        // {exMemRead, exRt, idRs, idRt, idUsesRt}
        for (int c = 0; c < 6; c++) begin
            clearIn();
            case (c)
                0: begin exMemRead = 1; exRt = 5; idRs = 5; end
                1: begin exMemRead = 1; exRt = 0; idRs = 0; end
                2: begin exMemRead = 1; exRt = 7; idRt = 7; idUsesRt = 0; end
                3: begin exMemRead = 1; exRt = 7; idRt = 7; idUsesRt = 1; end
                4: begin exMemRead = 0; exRt = 5; idRs = 5; end
                default: ;
            endcase
            sample();
            compared++;
            if (gotA !== expV[0]) begin mismatched++; $display("FAIL load_use_A c=%0d got=%h exp=%h", c, gotA, expV[0]); end
            compared++;
            if (gotB !== expV[1]) begin mismatched++; $display("FAIL load_use_B c=%0d got=%h exp=%h", c, gotB, expV[1]); end
            if (c == 0 || c == 3) begin
                compared++;
                if ({opA, pcA, ifA} !== 3'b000) begin mismatched++; $display("FAIL load_use_stall c=%0d got=%b exp=000", c, {opA, pcA, ifA}); end
            end
            advance();
        end
    endtask

    task automatic test_memwait();
        int heldA;
        clearIn(); pulseReset();
        heldA = 0;
        memAccess = 1;
        for (int c = 0; c < 8; c++) begin    // two back-to-back accesses on A
            sample();
            heldA += hdA;
            compared++;
            if (gotA !== expV[0]) begin mismatched++; $display("FAIL memwait_A c=%0d got=%h exp=%h", c, gotA, expV[0]); end
            compared++;
            if (gotB !== expV[1]) begin mismatched++; $display("FAIL memwait_B c=%0d got=%h exp=%h", c, gotB, expV[1]); end
            if (c == 3 || c == 7) begin
                compared++;
                if (hdA !== 1'b0) begin mismatched++; $display("FAIL memwait_release c=%0d got=%b exp=0", c, hdA); end
            end
            advance();
        end
        memAccess = 0;
        sample();
        compared++;
        if (heldA !== 6) begin mismatched++; $display("FAIL memwait_held got=%0d exp=6", heldA); end
        compared++;
        if (stA !== 4'd6) begin mismatched++; $display("FAIL memwait_stall_cnt got=%0d exp=6", stA); end
        advance();
    endtask

    task automatic test_flush();
        int flushedA;
        clearIn(); pulseReset();
        flushedA = 0;
        for (int c = 0; c < 5; c++) begin
            branchTaken = (c == 0);
            // wrong-path load-use during FLUSH must not freeze PC
            exMemRead = (c == 1); exRt = 3; idRs = 3;
            sample();
            flushedA += (flA && !opA);
            compared++;
            if (gotA !== expV[0]) begin mismatched++; $display("FAIL flush_A c=%0d got=%h exp=%h", c, gotA, expV[0]); end
            compared++;
            if (gotB !== expV[1]) begin mismatched++; $display("FAIL flush_B c=%0d got=%h exp=%h", c, gotB, expV[1]); end
            advance();
        end
        compared++;
        if (flushedA !== 3) begin mismatched++; $display("FAIL flush_slots got=%0d exp=3", flushedA); end
    endtask

    task automatic test_priority();
        clearIn(); pulseReset();
        branchTaken = 1; memAccess = 1;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) branchTaken = 0;
            if (c == 2) memAccess = 0;
            sample();
            compared++;
            if (gotA !== expV[0]) begin mismatched++; $display("FAIL priority_A c=%0d got=%h exp=%h", c, gotA, expV[0]); end
            compared++;
            if (gotB !== expV[1]) begin mismatched++; $display("FAIL priority_B c=%0d got=%h exp=%h", c, gotB, expV[1]); end
            if (c == 0) begin
                compared++;
                if ({hdB, flB} !== 2'b10) begin mismatched++; $display("FAIL priority_hold got=%b exp=10", {hdB, flB}); end
            end
            if (c == 1) begin
                compared++;
                if ({hdB, flB} !== 2'b01) begin mismatched++; $display("FAIL priority_flush got=%b exp=01", {hdB, flB}); end
            end
            advance();
        end
    endtask

    task automatic test_saturation();
        clearIn(); pulseReset();
        branchTaken = 1;
        for (int c = 0; c < 20; c++) begin
            sample();
            compared++;
            if (gotA !== expV[0]) begin mismatched++; $display("FAIL sat_A c=%0d got=%h exp=%h", c, gotA, expV[0]); end
            advance();
        end
        branchTaken = 0;
        sample();
        compared++;
        if (stA !== 4'hF) begin mismatched++; $display("FAIL sat_cnt_A got=%0d exp=15", stA); end
        compared++;
        if (stB !== 16'd20) begin mismatched++; $display("FAIL sat_cnt_B got=%0d exp=20", stB); end
        advance();
    endtask

    task automatic test_random();
        clearIn(); pulseReset();
        for (int c = 0; c < 400; c++) begin
            rstN        = ($urandom_range(0, 49) != 0);
            idRs        = 5'($urandom_range(0, 3));
            idRt        = 5'($urandom_range(0, 3));
            exRt        = 5'($urandom_range(0, 3));
            idUsesRt    = 1'($urandom_range(0, 1));
            exMemRead   = 1'($urandom_range(0, 1));
            memAccess   = ($urandom_range(0, 3) == 0);
            branchTaken = ($urandom_range(0, 5) == 0);
            sample();
            compared++;
            if (gotA !== expV[0]) begin mismatched++; $display("FAIL random_A c=%0d got=%h exp=%h", c, gotA, expV[0]); end
            compared++;
            if (gotB !== expV[1]) begin mismatched++; $display("FAIL random_B c=%0d got=%h exp=%h", c, gotB, expV[1]); end
            advance();
        end
        rstN = 1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_memwait();
        test_flush();
        test_priority();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
